// File: rtl/confreg_pkg.sv
// Shared register-map constants and byte-lane helper for the confreg block.
package confreg_pkg;

    // Word indices of each register within the 256-byte window (byte offset >> 2).
    localparam logic [5:0] OFF_LED      = 6'h00;
    localparam logic [5:0] OFF_SWITCH   = 6'h01;
    localparam logic [5:0] OFF_NUM      = 6'h02;
    localparam logic [5:0] OFF_COUNT    = 6'h03;
    localparam logic [5:0] OFF_CMP      = 6'h04;
    localparam logic [5:0] OFF_CTRL     = 6'h05;
    localparam logic [5:0] OFF_PRESCALE = 6'h06;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_AUTO_RELOAD = 2;
    localparam int CTRL_IRQ_STATUS  = 3;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] result;
        for (int i = 0; i < 4; i++)
            result[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return result;
    endfunction

endpackage

// File: rtl/confreg_timer.sv
// Prescaled 32-bit timer with compare match, optional auto-reload and sticky IRQ status.
module confreg_timer
    import confreg_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_auto_reload,
    input  logic [15:0] i_prescale,
    input  logic        i_prescale_wr,
    input  logic [3:0]  i_count_be,
    input  logic [3:0]  i_cmp_be,
    input  logic [31:0] i_wdata,
    input  logic        i_irq_clr,
    output logic [31:0] o_count,
    output logic [31:0] o_cmp,
    output logic        o_irq_status
);

    logic [15:0] r_pc;
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_irq_status;

    logic        w_tick;
    logic        w_match;
    logic [31:0] w_count_adv;
    logic [31:0] w_count_next;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        w_tick      = i_en && (r_pc == i_prescale);
        w_match     = (r_count == r_cmp);
        w_count_adv = r_count;
        if (w_tick)
            w_count_adv = (w_match && i_auto_reload) ? 32'd0 : r_count + 32'd1;
        // Software bytes override the tick result; unwritten bytes keep the tick value.
        w_count_next = byte_merge(w_count_adv, i_wdata, i_count_be);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= 16'd0;
            r_count      <= 32'd0;
            r_cmp        <= CMP_RESET;
            r_irq_status <= 1'b0;
        end else begin
            if (i_prescale_wr || !i_en || w_tick)
                r_pc <= 16'd0;
            else
                r_pc <= r_pc + 16'd1;
            r_count <= w_count_next;
            r_cmp   <= byte_merge(r_cmp, i_wdata, i_cmp_be);
            // A match in the same cycle as a clear must win.
            if (w_tick && w_match)
                r_irq_status <= 1'b1;
            else if (i_irq_clr)
                r_irq_status <= 1'b0;
        end
    end

    assign o_count      = r_count;
    assign o_cmp        = r_cmp;
    assign o_irq_status = r_irq_status;

endmodule

// File: rtl/confreg.sv
// Memory-mapped configuration registers: LEDs, synchronized switches, 7-seg value, timer.
module confreg
    import confreg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hBFAF_F000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_memwrite,
    input  logic [31:0] i_dataadr,
    input  logic [31:0] i_writedata,
    output logic [31:0] o_readdata,
    output logic        o_sel,
    input  logic [15:0] i_switch,
    output logic [15:0] o_led,
    output logic [31:0] o_num_data,
    output logic        o_timer_irq
);

    logic [15:0] r_led;
    logic [15:0] r_sync1;
    logic [15:0] r_sync2;
    logic [31:0] r_num;
    logic [2:0]  r_ctrl;
    logic [15:0] r_prescale;

    logic        w_sel;
    logic        w_wr;
    logic [5:0]  w_off;
    logic [3:0]  w_led_be, w_num_be, w_count_be, w_cmp_be, w_ctrl_be, w_pre_be;
    logic [31:0] w_count;
    logic [31:0] w_cmp;
    logic        w_irq_status;
    logic        w_unused_ok;

    assign w_sel       = (i_dataadr[31:8] == BASE_ADDR[31:8]);
    assign w_off       = i_dataadr[7:2];
    assign w_wr        = w_sel && (|i_memwrite);
    assign w_unused_ok = &{1'b0, i_dataadr[1:0]};

    always_comb begin
        w_led_be   = (w_wr && w_off == OFF_LED)      ? i_memwrite : 4'b0000;
        w_num_be   = (w_wr && w_off == OFF_NUM)      ? i_memwrite : 4'b0000;
        w_count_be = (w_wr && w_off == OFF_COUNT)    ? i_memwrite : 4'b0000;
        w_cmp_be   = (w_wr && w_off == OFF_CMP)      ? i_memwrite : 4'b0000;
        w_ctrl_be  = (w_wr && w_off == OFF_CTRL)     ? i_memwrite : 4'b0000;
        w_pre_be   = (w_wr && w_off == OFF_PRESCALE) ? i_memwrite : 4'b0000;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_led      <= 16'd0;
            r_sync1    <= 16'd0;
            r_sync2    <= 16'd0;
            r_num      <= 32'd0;
            r_ctrl     <= 3'd0;
            r_prescale <= 16'd0;
        end else begin
            r_sync1 <= i_switch;
            r_sync2 <= r_sync1;
            if (w_led_be[0]) r_led[7:0]       <= i_writedata[7:0];
            if (w_led_be[1]) r_led[15:8]      <= i_writedata[15:8];
            if (w_pre_be[0]) r_prescale[7:0]  <= i_writedata[7:0];
            if (w_pre_be[1]) r_prescale[15:8] <= i_writedata[15:8];
            if (w_ctrl_be[0]) r_ctrl          <= i_writedata[2:0];
            r_num <= byte_merge(r_num, i_writedata, w_num_be);
        end
    end

    confreg_timer u_timer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (r_ctrl[CTRL_EN]),
        .i_auto_reload (r_ctrl[CTRL_AUTO_RELOAD]),
        .i_prescale    (r_prescale),
        .i_prescale_wr (|w_pre_be),
        .i_count_be    (w_count_be),
        .i_cmp_be      (w_cmp_be),
        .i_wdata       (i_writedata),
        .i_irq_clr     (w_ctrl_be[0] && i_writedata[CTRL_IRQ_STATUS]),
        .o_count       (w_count),
        .o_cmp         (w_cmp),
        .o_irq_status  (w_irq_status)
    );

    always_comb begin
        o_readdata = 32'd0;
        if (w_sel) begin
            case (w_off)
                OFF_LED:      o_readdata = {16'd0, r_led};
                OFF_SWITCH:   o_readdata = {16'd0, r_sync2};
                OFF_NUM:      o_readdata = r_num;
                OFF_COUNT:    o_readdata = w_count;
                OFF_CMP:      o_readdata = w_cmp;
                OFF_CTRL:     o_readdata = {28'd0, w_irq_status, r_ctrl};
                OFF_PRESCALE: o_readdata = {16'd0, r_prescale};
                default:      o_readdata = 32'd0;
            endcase
        end
    end

    assign o_sel       = w_sel;
    assign o_led       = r_led;
    assign o_num_data  = r_num;
    assign o_timer_irq = w_irq_status && r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_confreg.sv
// Directed bench for confreg: register-map vectors plus timer, W1C, switch and reset sequences.
module tb_confreg;

    localparam logic [31:0] BASE = 32'hBFAF_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        sel;
    logic [15:0] switch_in;
    logic [15:0] led;
    logic [31:0] num_data;
    logic        timer_irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    confreg dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_memwrite  (memwrite),
        .i_dataadr   (dataadr),
        .i_writedata (writedata),
        .o_readdata  (readdata),
        .o_sel       (sel),
        .i_switch    (switch_in),
        .o_led       (led),
        .o_num_data  (num_data),
        .o_timer_irq (timer_irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_sel;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a store that is captured by the next rising edge; returns just after that edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        dataadr   = addr;
        writedata = data;
        memwrite  = be;
        @(posedge clk);
        #1;
        memwrite  = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        memwrite = 4'b0000;
        dataadr  = addr;
        #1;
        data = readdata;
    endtask

    vec_t        vecs [17];
    logic [31:0] d;
    logic [31:0] exp_cnt;

    initial begin
        rst       = 1'b1;
        memwrite  = 4'b0000;
        dataadr   = 32'd0;
        writedata = 32'd0;
        switch_in = 16'd0;

        vecs[0]  = '{BASE + 32'h00, 4'b0000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[1]  = '{BASE + 32'h04, 4'b0000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[2]  = '{BASE + 32'h08, 4'b0000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[3]  = '{BASE + 32'h0C, 4'b0000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[4]  = '{BASE + 32'h10, 4'b0000, 32'h0,         32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{BASE + 32'h14, 4'b0000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[6]  = '{BASE + 32'h18, 4'b0000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[7]  = '{BASE + 32'h1C, 4'b0000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[8]  = '{BASE + 32'h00, 4'b0001, 32'h1234_56AB, 32'h0000_00AB, 1'b1};
        vecs[9]  = '{BASE + 32'h00, 4'b1111, 32'h1234_56AB, 32'h0000_56AB, 1'b1};
        vecs[10] = '{BASE + 32'h08, 4'b0110, 32'hDEAD_BEEF, 32'h00AD_BE00, 1'b1};
        vecs[11] = '{BASE + 32'h18, 4'b1111, 32'hFFFF_1234, 32'h0000_1234, 1'b1};
        vecs[12] = '{BASE + 32'h20, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[13] = '{32'h0000_0008, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[14] = '{BASE + 32'h08, 4'b0000, 32'h0,         32'h00AD_BE00, 1'b1};
        vecs[15] = '{BASE + 32'hFC, 4'b0000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[16] = '{BASE + 32'h14, 4'b1110, 32'h0000_0707, 32'h0000_0000, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("irq_after_reset", {31'd0, timer_irq}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].be != 4'b0000)
                wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            else begin
                @(posedge clk);
                #1;
            end
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
            check($sformatf("vec%0d_sel", i), {31'd0, sel}, {31'd0, vecs[i].exp_sel});
        end
        check("led_pin", {16'd0, led}, 32'h0000_56AB);
        check("num_pin", num_data, 32'h00AD_BE00);

        // Timer: PRESCALE=3, CMP=2, EN|IRQ_EN|AUTO_RELOAD enabled at edge E0.
        wr(BASE + 32'h18, 32'd3, 4'b1111);
        wr(BASE + 32'h10, 32'd2, 4'b1111);
        wr(BASE + 32'h14, 32'h7, 4'b0001);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            exp_cnt = (k < 4) ? 32'd0 : (k < 8) ? 32'd1 : (k < 12) ? 32'd2 : 32'd0;
            rd(BASE + 32'h0C, d);
            check($sformatf("count_k%0d", k), d, exp_cnt);
            check($sformatf("irq_k%0d", k), {31'd0, timer_irq}, {31'd0, (k >= 12)});
        end
        rd(BASE + 32'h14, d);
        check("ctrl_status_set", d, 32'h0000_000F);

        // W1C at E13 (no tick) clears status.
        wr(BASE + 32'h14, 32'h0F, 4'b0001);
        rd(BASE + 32'h14, d);
        check("w1c_clear", d, 32'h0000_0007);
        check("irq_cleared", {31'd0, timer_irq}, 32'd0);

        // W1C landing on the matching tick at E24: set wins.
        repeat (10) @(posedge clk);
        #1;
        rd(BASE + 32'h0C, d);
        check("count_before_match", d, 32'd2);
        wr(BASE + 32'h14, 32'h0F, 4'b0001);
        rd(BASE + 32'h14, d);
        check("set_beats_w1c", d, 32'h0000_000F);
        check("irq_set_beats_w1c", {31'd0, timer_irq}, 32'd1);
        rd(BASE + 32'h0C, d);
        check("count_reloaded", d, 32'd0);
        wr(BASE + 32'h14, 32'h0F, 4'b0001);
        rd(BASE + 32'h14, d);
        check("w1c_no_tick", d, 32'h0000_0007);
        check("irq_low_again", {31'd0, timer_irq}, 32'd0);

        // COUNT write landing on the tick at E28 beats the increment.
        repeat (2) @(posedge clk);
        wr(BASE + 32'h0C, 32'h0000_0010, 4'b1111);
        rd(BASE + 32'h0C, d);
        check("count_write_beats_tick", d, 32'h0000_0010);
        repeat (4) @(posedge clk);
        #1;
        rd(BASE + 32'h0C, d);
        check("count_next_tick", d, 32'h0000_0011);

        // Switch synchronizer: visible exactly two edges after the pin changes.
        @(posedge clk);
        #1;
        switch_in = 16'hA5A5;
        rd(BASE + 32'h04, d);
        check("switch_lat0", d, 32'h0000_0000);
        @(posedge clk);
        #1;
        rd(BASE + 32'h04, d);
        check("switch_lat1", d, 32'h0000_0000);
        @(posedge clk);
        #1;
        rd(BASE + 32'h04, d);
        check("switch_lat2", d, 32'h0000_A5A5);

        // Mid-operation reset.
        wr(BASE + 32'h14, 32'h0000_0002, 4'b0001);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_num", num_data, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        rd(BASE + 32'h10, d);
        check("rst_cmp", d, 32'hFFFF_FFFF);
        rd(BASE + 32'h0C, d);
        check("rst_count", d, 32'd0);
        rd(BASE + 32'h14, d);
        check("rst_ctrl", d, 32'd0);
        rd(BASE + 32'h18, d);
        check("rst_prescale", d, 32'd0);
        rd(BASE + 32'h04, d);
        check("rst_switch", d, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/confreg.md
# confreg

Memory-mapped configuration/peripheral register block on the CPU data port, in parallel with `data_mem`. It consumes the same byte-enabled store bus the core drives (`memwrite[3:0]`, `dataadr`, `writedata`) and returns `readdata` for loads in its address window. It holds the board LEDs, a synchronized switch input, a seven-segment display value, and a prescaled 32-bit timer with compare interrupt. The SoC top muxes `readdata` from this block or `data_mem` by address.

## Interface
- `BASE_ADDR`, default 32'hBFAF_F000; window base, decoded on bits [31:8].
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `memwrite`  in  4  byte write enables; bit i writes `writedata[8i+7:8i]`.
- `dataadr`  in  32  byte address from core.
- `writedata`  in  32  store data.
- `readdata`  out  32  load data; combinational from registers.
- `sel`  out  1  high when `dataadr` is in window; used by top for read mux.
- `switch`  in  16  asynchronous board switches.
- `led`  out  16  LED register.
- `num_data`  out  32  seven-segment display value.
- `timer_irq`  out  1  level interrupt = IRQ_STATUS & IRQ_EN.

## Operation
- Decode: `sel = (dataadr[31:8] == BASE_ADDR[31:8])`; offset = `dataadr[7:2]`. Writes act only when `sel` and any `memwrite` bit set; per-byte masking on every writable register.
- Register map (word offsets in bytes):
  - 0x00 LED: bits [15:0] RW, [31:16] read 0. Reset 0.
  - 0x04 SWITCH: RO, 2-flop synchronized `switch`, zero-extended. Reset 0.
  - 0x08 NUM: 32-bit RW, drives `num_data`. Reset 0.
  - 0x0C COUNT: 32-bit RW timer value. Reset 0.
  - 0x10 CMP: 32-bit RW compare. Reset 32'hFFFF_FFFF.
  - 0x14 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD RW; bit3 IRQ_STATUS, write-1-to-clear (byte 0 enable required). Reset 0.
  - 0x18 PRESCALE: 16-bit RW, bits [31:16] read 0. Reset 0.
- Unmapped offsets: read 0, writes ignored. `readdata` = 0 when `sel` low.
- Timer: internal 16-bit prescale counter `pc`. When EN: if `pc == PRESCALE`, `pc <= 0` and tick; else `pc <= pc+1`. When EN low, `pc` held at 0, no ticks.
- On tick: if `COUNT == CMP`, set IRQ_STATUS and `COUNT <= AUTO_RELOAD ? 0 : COUNT+1`; else `COUNT <= COUNT+1` (wraps FFFF_FFFF->0).
- Priority: software write to COUNT beats tick update same cycle (bytes not written take tick value). IRQ set beats W1C in same cycle. Write to PRESCALE also resets `pc` to 0.

## Timing
- Writes take effect on the rising edge ending the store cycle; a load in the next cycle returns new value.
- Reads are zero-latency (combinational); core samples in same cycle.
- PRESCALE = N yields one tick every N+1 enabled cycles; first tick N+1 cycles after EN set.
- IRQ_STATUS visible (and `timer_irq` if IRQ_EN) the cycle after the matching tick edge.
- SWITCH latency 2 cycles from pin change to readable.
- `rst` mid-operation: all registers to reset values on that edge, `pc` to 0, outputs `led=0`, `num_data=0`, `timer_irq=0`, sync flops 0.

## Structure
- Shared package `confreg_pkg`: offset constants (OFF_LED … OFF_PRESCALE), CTRL bit indices, CMP reset value.
- One sub-module `confreg_timer`: prescaler, COUNT, compare, IRQ_STATUS; takes decoded write strobes/byte masks from the top-level register decode.

## Test plan
- Reset then read all offsets -> 0 except CMP = FFFF_FFFF; `timer_irq=0`.
- Byte write LED with `memwrite=4'b0001`, data 32'h1234_56AB -> LED reads 0000_00AB; write 4'b1111 → LED reads 0000_56AB.
- PRESCALE=3, CMP=2, CTRL=EN|IRQ_EN|AUTO_RELOAD -> COUNT 0,1,2 every 4 cycles, IRQ_STATUS set at count 2, COUNT returns to 0, `timer_irq` high.
- W1C CTRL bit3 on same cycle a match tick sets it -> IRQ_STATUS stays 1; next W1C without tick -> 0.
- COUNT write 0000_0010 on a tick cycle -> COUNT reads 0000_0010, not 0000_0011.
- Toggle `switch` to 16'hA5A5 -> SWITCH reads 0000_A5A5 exactly 2 cycles later; address outside window -> `sel=0`, `readdata=0`, no register change.
